// File: rtl/instr_dispatcher.sv
// Read-side sequencer for the instruction buffer: walks slots from 0 and hands each
// non-zero word to the execution unit until a zero terminator or the last slot.
module instr_dispatcher #(
  parameter int Instr_word_size = 32,
  parameter int bs              = 16,
  localparam int IW             = $clog2(bs)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [IW-1:0]              rd_index,
  input  logic [Instr_word_size-1:0] rd_data,
  output logic [Instr_word_size-1:0] instr_out,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic                       instr_last,
  output logic                       busy,
  output logic                       done,
  output logic [IW:0]                issued_count,
  output logic [2:0]                 dbg_state_o
);

  // Handshake: instr_out/instr_last are held while instr_valid is high; a word moves
  // on any rising edge with instr_valid & instr_ready, and instr_valid never drops
  // before that edge. instr_ready is ignored outside PRESENT.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_READ    = 3'd2,
    S_PRESENT = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  localparam logic [IW-1:0] LastIdx = IW'(bs - 1);

  state_t                       state_q;
  logic [IW-1:0]                idx_q;
  logic [Instr_word_size-1:0]   instr_q;
  logic                         valid_q;
  logic                         last_q;
  logic                         busy_q;
  logic                         done_q;
  logic [IW:0]                  cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          state_q <= S_READ;
        end
        S_READ: begin
          if (rd_data == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            instr_q <= rd_data;
            valid_q <= 1'b1;
            last_q  <= (idx_q == LastIdx);
            state_q <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (instr_ready) begin
            cnt_q   <= cnt_q + 1'b1;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            // Last slot exits directly so the index never wraps back to 0.
            if (idx_q == LastIdx) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_ADDR;
            end
          end
        end
        S_FINISH: begin
          if (!start) state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_index     = idx_q;
  assign instr_out    = instr_q;
  assign instr_valid  = valid_q;
  assign instr_last   = last_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign issued_count = cnt_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_instr_dispatcher.sv
// Bench for instr_dispatcher: a registered-read buffer model, a ready driver and a
// scoreboard fed by a reference model of which words a run must deliver.
module tb_instr_dispatcher;

  localparam int W  = 32;
  localparam int BS = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    rd_index;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  instr_out;
  logic          instr_valid;
  logic          instr_ready;
  logic          instr_last;
  logic          busy;
  logic          done;
  logic [4:0]    issued_count;
  logic [2:0]    dbg_state;

  instr_dispatcher #(.Instr_word_size(W), .bs(BS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rd_index     (rd_index),
    .rd_data      (rd_data),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_last   (instr_last),
    .busy         (busy),
    .done         (done),
    .issued_count (issued_count),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset / buffer model ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic [W-1:0] mem [BS];
  always @(posedge clk) rd_data <= mem[rd_index];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_last_q[$];
  int           exp_n;
  int           xfer_q[$];
  int           first_valid_cyc;
  int           done_cnt;
  int           done_cyc;
  int           done_idx;
  int           bp_cycles;
  logic         bp_prev;
  logic         prev_done;
  logic [37:0]  bp_vec;
  int           ready_mode = 0;
  int           bp_left;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: deliver slots in order up to the first zero word or the end of the buffer.
  task automatic build_expect();
    exp_q.delete();
    exp_last_q.delete();
    exp_n = 0;
    for (int i = 0; i < BS; i++) begin
      if (mem[i] == '0) break;
      exp_q.push_back(mem[i]);
      exp_last_q.push_back(i == BS - 1);
      exp_n++;
    end
  endtask

  // ---------------- ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: instr_ready = 1'b1;
      1: instr_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (instr_valid && rd_index == 4'd1 && bp_left > 0) begin
          instr_ready = 1'b0;
          bp_left--;
        end else begin
          instr_ready = 1'b1;
        end
      end
      default: instr_ready = 1'b0;
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      bp_prev   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (bp_prev)
        check("bp_stable", {instr_out, instr_valid, instr_last, rd_index}, bp_vec);
      if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin
        check("done_width", prev_done, 0);
        done_cnt++;
        done_cyc = cyc;
        done_idx = rd_index;
      end
      if (instr_valid && instr_ready) begin
        xfer_q.push_back(cyc + 1);
        if (exp_q.size() == 0) begin
          check("xfer_extra", instr_out, 0);
        end else begin
          check("xfer_data", instr_out, exp_q.pop_front());
          check("xfer_last", instr_last, exp_last_q.pop_front());
        end
      end
      if (instr_valid && !instr_ready) bp_cycles++;
      bp_prev   = instr_valid && !instr_ready;
      bp_vec    = {instr_out, instr_valid, instr_last, rd_index};
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_run(input int mode, input int hold);
    int s;
    build_expect();
    xfer_q.delete();
    first_valid_cyc = -1;
    done_cnt  = 0;
    done_cyc  = -1;
    done_idx  = -1;
    bp_cycles = 0;
    bp_left   = 5;
    ready_mode = mode;
    @(posedge clk);
    #1 start = 1'b1;
    s = cyc;
    @(posedge clk);
    @(negedge clk);
    check("cnt_clear", issued_count, 0);
    check("busy_run", busy, 1);
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      if (done_cnt > 0) break;
    end
    if (done_cnt == 0) check("done_timeout", done_cnt, 1);
    repeat (hold) @(posedge clk);
    #1 start = 1'b0;
    check("issued", issued_count, exp_n);
    check("done_cnt", done_cnt, 1);
    check("busy_end", busy, 0);
    check("exp_left", exp_q.size(), 0);
    check("xfer_n", xfer_q.size(), exp_n);
    if (exp_n == BS) check("done_idx", done_idx, BS - 1);
    if (mode == 2) check("bp_cycles", bp_cycles, 5);
    if (mode == 0) begin
      if (exp_n == 0) begin
        check("no_valid", first_valid_cyc, -1);
        check("done_lat", done_cyc, s + 3);
      end else begin
        check("first_valid", first_valid_cyc, s + 3);
        for (int i = 1; i < xfer_q.size(); i++)
          check("xfer_gap", xfer_q[i] - xfer_q[i-1], 3);
        check("done_lat", done_cyc, (exp_n == BS) ? xfer_q[$] : xfer_q[$] + 2);
      end
    end
  endtask

  task automatic load_abc();
    for (int i = 0; i < BS; i++) mem[i] = 32'hDEAD_0000 + W'(i);
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[3] = 32'h0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int term;
    rst = 1'b1;
    start = 1'b1;
    instr_ready = 1'b0;
    for (int i = 0; i < BS; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_index", rd_index, 0);
    check("rst_instr", instr_out, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_last", instr_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", issued_count, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    load_abc();
    do_run(0, 0);

    for (int i = 0; i < BS; i++) mem[i] = 32'h100 + W'(i);
    do_run(0, 0);

    load_abc();
    do_run(2, 0);

    mem[0] = '0;
    do_run(0, 0);

    load_abc();
    do_run(0, 8);
    load_abc();
    do_run(0, 0);

    for (int r = 0; r < 10; r++) begin
      term = $urandom_range(0, BS);
      for (int i = 0; i < BS; i++)
        mem[i] = (i == term) ? '0 : (i > term ? W'($urandom) : (W'($urandom) | 32'h1));
      do_run(1, $urandom_range(0, 3));
    end

    // Reset in the middle of a run, with start held high.
    load_abc();
    build_expect();
    ready_mode = 3;
    @(posedge clk);
    #1 start = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (instr_valid) break;
    end
    check("pre_rst_valid", instr_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_index", rd_index, 0);
    check("arst_instr", instr_out, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_count", issued_count, 0);
    repeat (2) @(negedge clk);
    check("rst_hold_busy", busy, 0);
    check("rst_hold_done", done, 0);
    start = 1'b0;
    rst = 1'b0;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
